// File: rtl/ama_riscv_reg_file_sb.sv
// Parametrised register file with pending-write scoreboard and zero-init sweep.
// Optional same-cycle writeback forwarding: define RF_BYPASS_EN.
module ama_riscv_reg_file_sb #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   addr_d,
  input  logic [XLEN-1:0] data_d,
  input  logic [AW-1:0]   addr_a,
  input  logic [AW-1:0]   addr_b,
  output logic [XLEN-1:0] data_a,
  output logic [XLEN-1:0] data_b,
  input  logic            sb_set,
  input  logic [AW-1:0]   sb_addr,
  output logic            busy_a,
  output logic            busy_b,
  input  logic            clr_req,
  output logic            ready
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  state_t             state;
  logic [AW-1:0]      cnt;
  logic [NREGS-1:0]   sb;
  logic [XLEN-1:0]    mem [1:NREGS-1];
  logic               run;
  logic               wr_ok;

  assign run   = (state == RUN);
  assign wr_ok = we && (addr_d != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      cnt   <= AW'(1);
      sb    <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + AW'(1);
          if (cnt == LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          if (clr_req) begin
            state <= INIT;
            cnt   <= AW'(1);
            sb    <= '0;
            ready <= 1'b0;
          end else begin
            // set after clear: a new producer supersedes the retiring one
            if (wr_ok)
              sb[addr_d] <= 1'b0;
            if (sb_set && sb_addr != '0)
              sb[sb_addr] <= 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // no reset on the array so it can map to distributed RAM
  always_ff @(posedge clk) begin
    if (!run)
      mem[cnt] <= '0;
    else if (wr_ok)
      mem[addr_d] <= data_d;
  end

  always_comb begin
    data_a = '0;
    busy_a = 1'b0;
    if (run && addr_a != '0) begin
      data_a = mem[addr_a];
      busy_a = sb[addr_a];
`ifdef RF_BYPASS_EN
      if (we && addr_d == addr_a) begin
        data_a = data_d;
        busy_a = sb_set && (sb_addr == addr_a);
      end
`endif
    end
  end

  always_comb begin
    data_b = '0;
    busy_b = 1'b0;
    if (run && addr_b != '0) begin
      data_b = mem[addr_b];
      busy_b = sb[addr_b];
`ifdef RF_BYPASS_EN
      if (we && addr_d == addr_b) begin
        data_b = data_d;
        busy_b = sb_set && (sb_addr == addr_b);
      end
`endif
    end
  end

endmodule

// File: tb/tb_ama_riscv_reg_file_sb.sv
// Directed bench for ama_riscv_reg_file_sb: 32x32 default and 16x64 instance.
// Inputs change on negedge; outputs sampled at negedge or just after.
module tb_ama_riscv_reg_file_sb;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  addr_d;
  logic [31:0] data_d;
  logic [4:0]  addr_a;
  logic [4:0]  addr_b;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic        busy_a;
  logic        busy_b;
  logic        clr_req;
  logic        ready;

  logic        w_we;
  logic [3:0]  w_addr_d;
  logic [63:0] w_data_d;
  logic [3:0]  w_addr_a;
  logic [3:0]  w_addr_b;
  logic [63:0] w_data_a;
  logic [63:0] w_data_b;
  logic        w_sb_set;
  logic [3:0]  w_sb_addr;
  logic        w_busy_a;
  logic        w_busy_b;
  logic        w_clr_req;
  logic        w_ready;

  int checks;
  int failures;
  int n;
  int n2;

  ama_riscv_reg_file_sb dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .addr_d  (addr_d),
    .data_d  (data_d),
    .addr_a  (addr_a),
    .addr_b  (addr_b),
    .data_a  (data_a),
    .data_b  (data_b),
    .sb_set  (sb_set),
    .sb_addr (sb_addr),
    .busy_a  (busy_a),
    .busy_b  (busy_b),
    .clr_req (clr_req),
    .ready   (ready)
  );

  ama_riscv_reg_file_sb #(.XLEN(64), .NREGS(16)) dut_w (
    .clk     (clk),
    .rst     (rst),
    .we      (w_we),
    .addr_d  (w_addr_d),
    .data_d  (w_data_d),
    .addr_a  (w_addr_a),
    .addr_b  (w_addr_b),
    .data_a  (w_data_a),
    .data_b  (w_data_b),
    .sb_set  (w_sb_set),
    .sb_addr (w_sb_addr),
    .busy_a  (w_busy_a),
    .busy_b  (w_busy_b),
    .clr_req (w_clr_req),
    .ready   (w_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    we = 0; addr_d = 0; data_d = 0;
    addr_a = 0; addr_b = 0;
    sb_set = 0; sb_addr = 0; clr_req = 0;
    w_we = 0; w_addr_d = 0; w_data_d = 0;
    w_addr_a = 0; w_addr_b = 0;
    w_sb_set = 0; w_sb_addr = 0; w_clr_req = 0;
    #1;
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_busy_a", 64'(busy_a), 64'd0);
    chk("rst_data_a", 64'(data_a), 64'd0);
    cyc();
    cyc();

    // 1. reset sweep length, both instances
    rst = 1'b0;
    addr_a = 5'd3;
    n = 0;
    n2 = -1;
    while (!ready && n < 100) begin
      if (n == 5) begin
        #1;
        chk("init_data_a", 64'(data_a), 64'd0);
        chk("init_busy_a", 64'(busy_a), 64'd0);
      end
      cyc();
      n++;
      if (w_ready && n2 < 0) n2 = n;
    end
    chk("sweep_len32", 64'(n), 64'd31);
    chk("sweep_len16", 64'(n2), 64'd15);

    // reset pulsed at sweep cycle 10
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (10) cyc();
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(ready), 64'd0);
    cyc();
    rst = 1'b0;
    n = 0;
    while (!ready && n < 100) begin
      cyc();
      n++;
    end
    chk("sweep_restart", 64'(n), 64'd31);
    for (int i = 0; i < 32; i++) begin
      addr_a = 5'(i);
      addr_b = 5'(31 - i);
      #1;
      chk("zero_a", 64'(data_a), 64'd0);
      chk("zero_b", 64'(data_b), 64'd0);
    end
    cyc();

    // 2. basic write/read
    we = 1; addr_d = 5'd5; data_d = 32'hDEADBEEF;
    cyc();
    addr_d = 5'd31; data_d = 32'h12345678;
    cyc();
    we = 0;
    addr_a = 5'd5; addr_b = 5'd31;
    #1;
    chk("rd_x5", 64'(data_a), 64'hDEADBEEF);
    chk("rd_x31", 64'(data_b), 64'h12345678);
    cyc();
    we = 1; addr_d = 5'd0; data_d = 32'hFFFFFFFF;
    cyc();
    we = 0; addr_a = 5'd0;
    #1;
    chk("rd_x0", 64'(data_a), 64'd0);
    cyc();

    // 3. scoreboard
    sb_set = 1; sb_addr = 5'd7; addr_a = 5'd7; addr_b = 5'd7;
    cyc();
    sb_set = 0;
    #1;
    chk("sb_set_a", 64'(busy_a), 64'd1);
    chk("sb_set_b", 64'(busy_b), 64'd1);
    we = 1; addr_d = 5'd7; data_d = 32'h77;
    cyc();
    we = 0;
    #1;
    chk("sb_clr", 64'(busy_a), 64'd0);
    chk("sb_clr_data", 64'(data_a), 64'h77);
    sb_set = 1; sb_addr = 5'd7;
    we = 1; addr_d = 5'd7; data_d = 32'h99;
    cyc();
    sb_set = 0; we = 0;
    #1;
    chk("sb_set_wins", 64'(busy_a), 64'd1);
    chk("sb_both_data", 64'(data_a), 64'h99);
    we = 1; addr_d = 5'd7; data_d = 32'h99;
    cyc();
    we = 0;
    sb_set = 1; sb_addr = 5'd0; addr_a = 5'd0;
    cyc();
    sb_set = 0;
    #1;
    chk("sb_x0", 64'(busy_a), 64'd0);
    addr_a = 5'd7;
    #1;
    chk("sb_x7_free", 64'(busy_a), 64'd0);

    // 4. same-cycle write and read
    we = 1; addr_d = 5'd9; data_d = 32'h1;
    cyc();
    addr_d = 5'd9; data_d = 32'h2; addr_a = 5'd9;
    #1;
`ifdef RF_BYPASS_EN
    chk("same_cyc_data", 64'(data_a), 64'h2);
`else
    chk("same_cyc_data", 64'(data_a), 64'h1);
`endif
    chk("same_cyc_busy", 64'(busy_a), 64'd0);
    cyc();
    we = 0;
    #1;
    chk("next_cyc_data", 64'(data_a), 64'h2);

    // 5. clr_req sweep with pending write and busy bit
    we = 1; addr_d = 5'd3; data_d = 32'hA5A5A5A5;
    sb_set = 1; sb_addr = 5'd3;
    cyc();
    we = 0; sb_set = 0;
    we = 1; addr_d = 5'd4; data_d = 32'h44;
    cyc();
    we = 0; addr_a = 5'd3; addr_b = 5'd4;
    #1;
    chk("pre_clr_x3", 64'(data_a), 64'hA5A5A5A5);
    chk("pre_clr_busy", 64'(busy_a), 64'd1);
    clr_req = 1;
    cyc();
    clr_req = 0;
    chk("clr_ready_drop", 64'(ready), 64'd0);
    n = 0;
    while (!ready && n < 100) begin
      if (n == 10) begin
        we = 1; addr_d = 5'd4; data_d = 32'h55;
      end
      if (n == 11) begin
        chk("clr_init_busy", 64'(busy_a), 64'd0);
        chk("clr_init_data", 64'(data_b), 64'd0);
      end
      cyc();
      we = 0;
      n++;
    end
    chk("clr_sweep_len", 64'(n), 64'd31);
    #1;
    chk("clr_x3", 64'(data_a), 64'd0);
    chk("clr_x3_busy", 64'(busy_a), 64'd0);
    chk("clr_x4", 64'(data_b), 64'd0);
    cyc();

    // 6. 64-bit, 16-entry instance
    chk("w_ready", 64'(w_ready), 64'd1);
    w_we = 1; w_addr_d = 4'd15; w_data_d = 64'hFEDCBA9876543210;
    cyc();
    w_we = 0; w_addr_a = 4'd15; w_addr_b = 4'd1;
    #1;
    chk("w_rd_x15", w_data_a, 64'hFEDCBA9876543210);
    chk("w_rd_x1", w_data_b, 64'd0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
